// File: rtl/mux_nch_scan_pkg.sv
// Shared types and helpers for the N-channel scanning multiplexer.
package mux_nch_scan_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Dwell counter width: one bit of headroom over the terminal count.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mux_scan_seq.sv
// Scan sequencer: mode register, dwell counter and scan channel counter.
module mux_scan_seq
  import mux_nch_scan_pkg::*;
#(
  parameter  int unsigned NCH   = 4,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned SW    = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  output logic [SW-1:0] scan_ch,
  output logic          first_of_frame
);

  localparam int unsigned     DW         = cnt_width(DWELL);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SW-1:0]   CH_LAST    = SW'(NCH - 1);

  mode_e          mode_q,    mode_d;
  logic [SW-1:0]  scan_ch_q, scan_ch_d;
  logic [DW-1:0]  dwell_q,   dwell_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_DIRECT;
      scan_ch_q <= '0;
      dwell_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      scan_ch_q <= scan_ch_d;
      dwell_q   <= dwell_d;
    end
  end

  // Counters stay at zero in direct mode, so entering scan starts a fresh sweep.
  always_comb begin
    mode_d    = mode_q;
    scan_ch_d = scan_ch_q;
    dwell_d   = dwell_q;
    if (en) begin
      mode_d = mode_e'(mode);
      if (mode_d == MODE_DIRECT) begin
        scan_ch_d = '0;
        dwell_d   = '0;
      end else if (dwell_q == DWELL_LAST) begin
        dwell_d   = '0;
        scan_ch_d = (scan_ch_q == CH_LAST) ? '0 : scan_ch_q + SW'(1);
      end else begin
        dwell_d   = dwell_q + DW'(1);
      end
    end
  end

  assign scan_ch        = scan_ch_q;
  assign first_of_frame = (scan_ch_q == '0) && (dwell_q == '0);

endmodule

// File: rtl/mux_nch_scan.sv
// N-channel, W-bit registered multiplexer with direct select and auto-scan modes.
module mux_nch_scan
  import mux_nch_scan_pkg::*;
#(
  parameter  int unsigned NCH   = 4,
  parameter  int unsigned W     = 8,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned SW    = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  input  logic [NCH*W-1:0] din,
  output logic [W-1:0]     dout,
  output logic [SW-1:0]    ch_out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             sel_err
);

  logic [W-1:0]  ch_data [NCH];
  logic [SW-1:0] scan_ch;
  logic          first_of_frame;
  logic          sel_in_range;

  logic [W-1:0]  dout_q,        dout_d;
  logic [SW-1:0] ch_out_q,      ch_out_d;
  logic          out_valid_q,   out_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          sel_err_q,     sel_err_d;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign ch_data[k] = din[k*W +: W];
  end

  assign sel_in_range = ({1'b0, sel} < (SW+1)'(NCH));

  mux_scan_seq #(
    .NCH   (NCH),
    .DWELL (DWELL)
  ) u_seq (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .mode           (mode),
    .scan_ch        (scan_ch),
    .first_of_frame (first_of_frame)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q        <= '0;
      ch_out_q      <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      dout_q        <= dout_d;
      ch_out_q      <= ch_out_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      sel_err_q     <= sel_err_d;
    end
  end

  // Data/tag hold while disabled; the per-sample flags are single-cycle pulses.
  always_comb begin
    dout_d        = dout_q;
    ch_out_d      = ch_out_q;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    sel_err_d     = 1'b0;
    if (en) begin
      out_valid_d = 1'b1;
      if (mode_e'(mode) == MODE_SCAN) begin
        dout_d        = ch_data[scan_ch];
        ch_out_d      = scan_ch;
        frame_start_d = first_of_frame;
      end else if (sel_in_range) begin
        dout_d   = ch_data[sel];
        ch_out_d = sel;
      end else begin
        dout_d    = '0;
        ch_out_d  = sel;
        sel_err_d = 1'b1;
      end
    end
  end

  assign dout        = dout_q;
  assign ch_out      = ch_out_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_mux_nch_scan.sv
// Directed bench: 4-channel and 3-channel instances, both with a dwell of 2.
module tb_mux_nch_scan;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] din4;
  logic [23:0] din3;

  logic [7:0]  dout4,  dout3;
  logic [1:0]  ch4,    ch3;
  logic        vld4,   vld3;
  logic        fs4,    fs3;
  logic        err4,   err3;

  int checks = 0;
  int errors = 0;

  mux_nch_scan #(.NCH(4), .W(8), .DWELL(2)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din4),
    .dout(dout4), .ch_out(ch4), .out_valid(vld4), .frame_start(fs4), .sel_err(err4)
  );

  mux_nch_scan #(.NCH(3), .W(8), .DWELL(2)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din3),
    .dout(dout3), .ch_out(ch3), .out_valid(vld3), .frame_start(fs3), .sel_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] scan_exp [10];
    logic       fs_exp   [10];
    scan_exp = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h11, 8'h11};
    fs_exp   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst  = 1'b1;
    en   = 1'b1;
    mode = 1'b0;
    sel  = 2'd1;
    din4 = {8'h44, 8'h33, 8'h22, 8'h11};
    din3 = {8'hC3, 8'hB2, 8'hA1};

    // Reset with non-zero inputs
    tick();
    tick();
    check("rst_dout",  32'(dout4), 32'h0);
    check("rst_ch",    32'(ch4),   32'h0);
    check("rst_valid", 32'(vld4),  32'h0);
    check("rst_fs",    32'(fs4),   32'h0);
    check("rst_err",   32'(err4),  32'h0);
    check("rst_dout3", 32'(dout3), 32'h0);

    // Direct select
    rst = 1'b0;
    sel = 2'd0;
    tick();
    check("dir0_dout",  32'(dout4), 32'h11);
    check("dir0_ch",    32'(ch4),   32'h0);
    check("dir0_valid", 32'(vld4),  32'h1);
    sel = 2'd1;
    tick();
    check("dir1_dout", 32'(dout4), 32'h22);
    check("dir1_ch",   32'(ch4),   32'h1);
    sel = 2'd3;
    tick();
    check("dir3_dout",  32'(dout4), 32'h44);
    check("dir3_ch",    32'(ch4),   32'h3);
    check("dir3_valid", 32'(vld4),  32'h1);
    check("dir3_err",   32'(err4),  32'h0);

    // Scan sweep, dwell of 2
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("scan%0d_dout", i), 32'(dout4), 32'(scan_exp[i]));
      check($sformatf("scan%0d_fs", i),   32'(fs4),   32'(fs_exp[i]));
      check($sformatf("scan%0d_valid", i), 32'(vld4), 32'h1);
    end
    check("scan_ch_tag", 32'(ch4), 32'h0);

    // Back to direct clears the sweep; re-enter and gate mid-scan
    mode = 1'b0;
    sel  = 2'd3;
    tick();
    check("back_dir_dout", 32'(dout4), 32'h44);
    check("back_dir_fs",   32'(fs4),   32'h0);
    mode = 1'b1;
    tick();
    check("reentry_dout", 32'(dout4), 32'h11);
    check("reentry_fs",   32'(fs4),   32'h1);
    tick();
    check("reentry2_dout", 32'(dout4), 32'h11);
    tick();
    check("reentry3_dout", 32'(dout4), 32'h22);
    check("reentry3_ch",   32'(ch4),   32'h1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("gate%0d_dout", i),  32'(dout4), 32'h22);
      check($sformatf("gate%0d_valid", i), 32'(vld4),  32'h0);
      check($sformatf("gate%0d_fs", i),    32'(fs4),   32'h0);
    end
    en = 1'b1;
    tick();
    check("resume0_dout",  32'(dout4), 32'h22);
    check("resume0_valid", 32'(vld4),  32'h1);
    tick();
    check("resume1_dout", 32'(dout4), 32'h33);
    check("resume1_ch",   32'(ch4),   32'h2);

    // Reset mid-scan (channel 2 dwelling)
    rst = 1'b1;
    tick();
    check("midrst_dout",  32'(dout4), 32'h0);
    check("midrst_valid", 32'(vld4),  32'h0);
    check("midrst_ch",    32'(ch4),   32'h0);
    rst = 1'b0;
    tick();
    check("postrst_dout", 32'(dout4), 32'h11);
    check("postrst_ch",   32'(ch4),   32'h0);
    check("postrst_fs",   32'(fs4),   32'h1);

    // Out-of-range select on the 3-channel instance
    mode = 1'b0;
    sel  = 2'd3;
    tick();
    check("oor_dout3",  32'(dout3), 32'h0);
    check("oor_err3",   32'(err3),  32'h1);
    check("oor_ch3",    32'(ch3),   32'h3);
    check("oor_valid3", 32'(vld3),  32'h1);
    check("oor_err4",   32'(err4),  32'h0);
    sel = 2'd2;
    tick();
    check("inr_err3",  32'(err3),  32'h0);
    check("inr_dout3", 32'(dout3), 32'hC3);
    check("inr_ch3",   32'(ch3),   32'h2);

    // Out-of-range held while disabled: error does not persist
    sel = 2'd3;
    en  = 1'b0;
    tick();
    check("oor_dis_err3",  32'(err3),  32'h0);
    check("oor_dis_dout3", 32'(dout3), 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
